// File: rtl/audio_bridge_pkg.sv
// Shared register map, ID word and status/control bit positions for the audio stream bridge.
package audio_bridge_pkg;

  localparam logic [7:0]  ADDR_ID   = 8'h00;
  localparam logic [7:0]  ADDR_GSR  = 8'h01;
  localparam logic [7:0]  CH_BASE   = 8'h10;
  localparam int          CH_STRIDE = 4;

  typedef enum logic [1:0] {
    REG_SR   = 2'd0,
    REG_CTRL = 2'd1,
    REG_DOUT = 2'd2,
    REG_DIN  = 2'd3
  } ch_reg_e;

  localparam logic [31:0] ID_VALUE = 32'hCB1A_0000;

  localparam int SR_RX_OVF  = 0;
  localparam int SR_TX_UNF  = 1;
  localparam int SR_RX_WM   = 2;
  localparam int SR_TX_WM   = 3;
  localparam int SR_RX_NE   = 4;
  localparam int SR_TX_FULL = 5;
  localparam int SR_RX_LVL  = 8;
  localparam int SR_TX_LVL  = 16;

  localparam int CTRL_RXEN   = 0;
  localparam int CTRL_TXEN   = 1;
  localparam int CTRL_IE     = 4;
  localparam int CTRL_RX_THR = 8;
  localparam int CTRL_TX_THR = 16;

  // Storable CTRL bits; [3:2] are reserved and always read back as zero.
  localparam logic [23:0] CTRL_MASK = 24'hFF_FFF3;

  function automatic logic [31:0] id_word(input int nch, input int dw);
    return ID_VALUE | (32'(nch) << 8) | 32'(dw);
  endfunction

endpackage

// File: rtl/audio_bridge_fifo.sv
// Single-clock show-ahead FIFO with flush; fullness is tracked by the level counter.
module audio_bridge_fifo
#(
  parameter int W  = 24,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0]   DEPTH   = (AW+1)'(1) << AW;
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
      else if (!do_push && do_pop) level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/audio_stream_bridge.sv
// Register-to-stream bridge: host register bus in front of per-channel RX/TX sample FIFOs.
// Build option AUDIO_BRIDGE_SIGNEXT_EN: DIN reads sign-extend the sample; default zero-extends.
module audio_stream_bridge
  import audio_bridge_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int DW         = 24,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_err,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              irq,
  input  logic [NCH-1:0]    rx_vld,
  input  logic [NCH*DW-1:0] rx_data,
  input  logic [NCH-1:0]    tx_ack,
  output logic [NCH*DW-1:0] tx_data
);

  localparam int         LW      = DEPTH_LOG2 + 1;
  localparam logic [7:0] CH_SPAN = 8'(CH_STRIDE * NCH);

  logic [7:0]     wr_rel, rd_rel;
  logic           wr_in_ch, rd_in_ch;
  logic [NCH-1:0] wr_sel, rd_sel, sr_wr, ctrl_wr;
  logic [NCH-1:0] rx_push, rx_pop, tx_push, tx_pop;
  logic [NCH-1:0] rx_full, rx_empty, tx_full, tx_empty;
  logic [NCH-1:0] rxen, txen, pend;
  logic [LW-1:0]  rx_level [NCH];
  logic [LW-1:0]  tx_level [NCH];
  logic [DW-1:0]  rx_head  [NCH];
  logic [DW-1:0]  tx_head  [NCH];
  logic [31:0]    sr_val   [NCH];
  logic [23:0]    ctrl_q   [NCH];
  logic [23:0]    ctrl_d   [NCH];
  logic [NCH-1:0] rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic           rd_valid_q, irq_q;
  logic           unused_bits;

  assign wr_rel   = wr_addr - CH_BASE;
  assign rd_rel   = rd_addr - CH_BASE;
  assign wr_in_ch = (wr_addr >= CH_BASE) && (wr_rel < CH_SPAN);
  assign rd_in_ch = (rd_addr >= CH_BASE) && (rd_rel < CH_SPAN);
  assign unused_bits = ^{wr_data[31:24], wr_rel[7:6], rd_rel[7:6]};

  function automatic logic [31:0] ext_sample(input logic [DW-1:0] s);
    logic [31:0] r;
`ifdef AUDIO_BRIDGE_SIGNEXT_EN
    r = {32{s[DW-1]}};
`else
    r = '0;
`endif
    r[DW-1:0] = s;
    return r;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign rxen[c] = ctrl_q[c][CTRL_RXEN];
    assign txen[c] = ctrl_q[c][CTRL_TXEN];

    // A disabled direction holds its FIFO in flush, so clearing an enable empties it.
    audio_bridge_fifo #(.W(DW), .AW(DEPTH_LOG2)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (!rxen[c]),
      .push  (rx_push[c]),
      .pop   (rx_pop[c]),
      .din   (rx_data[c*DW +: DW]),
      .dout  (rx_head[c]),
      .level (rx_level[c]),
      .full  (rx_full[c]),
      .empty (rx_empty[c])
    );

    audio_bridge_fifo #(.W(DW), .AW(DEPTH_LOG2)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (!txen[c]),
      .push  (tx_push[c]),
      .pop   (tx_pop[c]),
      .din   (wr_data[DW-1:0]),
      .dout  (tx_head[c]),
      .level (tx_level[c]),
      .full  (tx_full[c]),
      .empty (tx_empty[c])
    );

    assign tx_data[c*DW +: DW] = (txen[c] && !tx_empty[c]) ? tx_head[c] : '0;
  end

  always_comb begin
    wr_sel  = '0;
    rd_sel  = '0;
    sr_wr   = '0;
    ctrl_wr = '0;
    rx_push = '0;
    rx_pop  = '0;
    tx_push = '0;
    tx_pop  = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_sel[c]  = wr_en && wr_in_ch && (wr_rel[5:2] == 4'(c));
      rd_sel[c]  = rd_en && rd_in_ch && (rd_rel[5:2] == 4'(c));
      sr_wr[c]   = wr_sel[c] && (wr_rel[1:0] == REG_SR);
      ctrl_wr[c] = wr_sel[c] && (wr_rel[1:0] == REG_CTRL);
      rx_push[c] = rx_vld[c] && rxen[c];
      rx_pop[c]  = rd_sel[c] && (rd_rel[1:0] == REG_DIN);
      tx_push[c] = wr_sel[c] && (wr_rel[1:0] == REG_DOUT) && txen[c];
      tx_pop[c]  = tx_ack[c] && txen[c];
    end
  end

  // Sticky flags: a set event in the same cycle as a write-1 clear wins.
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    tx_unf_d = tx_unf_q;
    pend     = '0;
    for (int c = 0; c < NCH; c++) begin
      rx_ovf_d[c] = (rx_ovf_q[c] && !(sr_wr[c] && wr_data[SR_RX_OVF]))
                    || (rx_push[c] && rx_full[c] && !rx_pop[c]);
      tx_unf_d[c] = (tx_unf_q[c] && !(sr_wr[c] && wr_data[SR_TX_UNF]))
                    || (tx_pop[c] && tx_empty[c]);
      ctrl_d[c]   = ctrl_wr[c] ? (wr_data[23:0] & CTRL_MASK) : ctrl_q[c];

      sr_val[c] = '0;
      sr_val[c][SR_RX_OVF]  = rx_ovf_q[c];
      sr_val[c][SR_TX_UNF]  = tx_unf_q[c];
      sr_val[c][SR_RX_WM]   = (8'(rx_level[c]) >= ctrl_q[c][CTRL_RX_THR +: 8])
                              && (rx_level[c] != '0);
      // TX watermark only means "room to refill" while the TX direction is running.
      sr_val[c][SR_TX_WM]   = txen[c] && (8'(tx_level[c]) <= ctrl_q[c][CTRL_TX_THR +: 8]);
      sr_val[c][SR_RX_NE]   = !rx_empty[c];
      sr_val[c][SR_TX_FULL] = tx_full[c];
      sr_val[c][SR_RX_LVL +: 8] = 8'(rx_level[c]);
      sr_val[c][SR_TX_LVL +: 8] = 8'(tx_level[c]);

      pend[c] = |(sr_val[c][3:0] & ctrl_q[c][CTRL_IE +: 4]);
    end
  end

  always_comb begin
    wr_err = 1'b0;
    if (wr_en) begin
      if (!wr_in_ch || (wr_rel[1:0] == REG_DIN)) wr_err = 1'b1;
      else if (wr_rel[1:0] == REG_DOUT)          wr_err = |(tx_push & tx_full & ~tx_pop);
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      if (rd_addr == ADDR_ID) begin
        rd_data_d = id_word(NCH, DW);
      end else if (rd_addr == ADDR_GSR) begin
        rd_data_d = 32'(pend);
      end else if (rd_in_ch) begin
        for (int c = 0; c < NCH; c++) begin
          if (rd_rel[5:2] == 4'(c)) begin
            case (ch_reg_e'(rd_rel[1:0]))
              REG_SR:   rd_data_d = sr_val[c];
              REG_CTRL: rd_data_d = {8'h00, ctrl_q[c]};
              REG_DIN:  rd_data_d = rx_empty[c] ? '0 : ext_sample(rx_head[c]);
              default:  rd_data_d = '0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) ctrl_q[c] <= '0;
      rx_ovf_q   <= '0;
      tx_unf_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) ctrl_q[c] <= ctrl_d[c];
      rx_ovf_q   <= rx_ovf_d;
      tx_unf_q   <= tx_unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      irq_q      <= |pend;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_audio_stream_bridge.sv
// Bench for audio_stream_bridge: register table, RX/TX FIFO sequences, read scoreboard.
module tb_audio_stream_bridge;

  localparam int NCH        = 2;
  localparam int DW         = 24;
  localparam int DEPTH_LOG2 = 4;

`ifdef AUDIO_BRIDGE_SIGNEXT_EN
  localparam logic [31:0] EXP_NEG = 32'hFF80_0001;
`else
  localparam logic [31:0] EXP_NEG = 32'h0080_0001;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              wr_err;
  logic              rd_en;
  logic [7:0]        rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              irq;
  logic [NCH-1:0]    rx_vld;
  logic [NCH*DW-1:0] rx_data;
  logic [NCH-1:0]    tx_ack;
  logic [NCH*DW-1:0] tx_data;

  audio_stream_bridge #(.NCH(NCH), .DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq),
    .rx_vld   (rx_vld),
    .rx_data  (rx_data),
    .tx_ack   (tx_ack),
    .tx_data  (tx_data)
  );

  // clock
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // scoreboard: every read pushes its expectation; rd_valid pops it
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no read data", rd_data);
      end else begin
        check(tag_q.pop_front(), rd_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks: inputs change on the falling edge, one cycle per call
  task automatic clr_in();
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    rx_vld = '0;
    tx_ack = '0;
  endtask

  task automatic nop();
    @(negedge clk);
    clr_in();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    clr_in();
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string t);
    @(negedge clk);
    clr_in();
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [21];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset
    rst     = 1'b1;
    clr_in();
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_tx_data", tx_data[31:0], 32'h0);

    // register map table: reads give rd_data, writes give wr_err
    vt[0]  = '{0, 8'h00, 32'h0,         32'hCB1A_0218};
    vt[1]  = '{0, 8'h01, 32'h0,         32'h0};
    vt[2]  = '{0, 8'h10, 32'h0,         32'h0};
    vt[3]  = '{0, 8'h11, 32'h0,         32'h0};
    vt[4]  = '{0, 8'h14, 32'h0,         32'h0};
    vt[5]  = '{0, 8'h15, 32'h0,         32'h0};
    vt[6]  = '{0, 8'h17, 32'h0,         32'h0};
    vt[7]  = '{0, 8'h18, 32'h0,         32'h0};
    vt[8]  = '{1, 8'h00, 32'h1,         32'h1};
    vt[9]  = '{1, 8'h01, 32'h1,         32'h1};
    vt[10] = '{1, 8'h13, 32'h1,         32'h1};
    vt[11] = '{1, 8'h18, 32'h1,         32'h1};
    vt[12] = '{1, 8'h0F, 32'h1,         32'h1};
    vt[13] = '{1, 8'h12, 32'h5,         32'h0};
    vt[14] = '{1, 8'h10, 32'h3,         32'h0};
    vt[15] = '{0, 8'h10, 32'h0,         32'h0};
    vt[16] = '{0, 8'h11, 32'h0,         32'h0};
    vt[17] = '{1, 8'h15, 32'hFFFF_FFF0, 32'h0};
    vt[18] = '{0, 8'h15, 32'h0,         32'h00FF_FFF0};
    vt[19] = '{1, 8'h15, 32'h0,         32'h0};
    vt[20] = '{0, 8'h15, 32'h0,         32'h0};
    for (int i = 0; i < 21; i++) begin
      if (vt[i].is_wr) begin
        wr(vt[i].addr, vt[i].data);
        #1 check($sformatf("tbl%0d_wr_err", i), 32'(wr_err), vt[i].exp);
      end else begin
        rd(vt[i].addr, vt[i].exp, $sformatf("tbl%0d_rd", i));
      end
    end
    nop();
    nop();
    check("tbl_irq", 32'(irq), 32'h0);

    // ch1 RX: fill past full, drain in order, clear overflow
    wr(8'h15, 32'h1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      clr_in();
      rx_vld = 2'b10;
      rx_data[47:24] = 24'(i);
    end
    nop();
    rd(8'h14, 32'h0000_1015, "rx_full_sr");
    for (int i = 0; i < 16; i++) rd(8'h17, 32'(i), $sformatf("rx_din%0d", i));
    rd(8'h17, 32'h0, "rx_din_empty");
    rd(8'h14, 32'h0000_0001, "rx_drained_sr");
    wr(8'h14, 32'h1);
    nop();
    rd(8'h14, 32'h0, "rx_ovf_cleared");
    check("rx_irq", 32'(irq), 32'h0);

    // ch0 TX: watermark interrupt, fill to full, simultaneous push/ack, drain
    wr(8'h11, 32'h0002_0082);
    for (int i = 0; i < 3; i++) begin
      wr(8'h12, 32'hA0 + 32'(i));
      #1 check($sformatf("tx_wr%0d_err", i), 32'(wr_err), 32'h0);
    end
    nop();
    nop();
    check("tx_lvl3_irq", 32'(irq), 32'h0);
    check("tx_head_a0", 32'(tx_data[23:0]), 32'hA0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clr_in();
      tx_ack = 2'b01;
    end
    nop();
    nop();
    check("tx_lvl1_irq", 32'(irq), 32'h1);
    check("tx_head_a2", 32'(tx_data[23:0]), 32'hA2);
    for (int k = 0; k < 16; k++) begin
      wr(8'h12, 32'h100 + 32'(k));
      #1 check($sformatf("tx_fill%0d_err", k), 32'(wr_err), (k == 15) ? 32'h1 : 32'h0);
    end
    nop();
    rd(8'h10, 32'h0010_0020, "tx_full_sr");
    @(negedge clk);
    clr_in();
    wr_en   = 1'b1;
    wr_addr = 8'h12;
    wr_data = 32'h1FF;
    tx_ack  = 2'b01;
    #1 check("tx_full_push_ack_err", 32'(wr_err), 32'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      clr_in();
      #1 check($sformatf("tx_drain%0d", k), 32'(tx_data[23:0]),
               (k == 15) ? 32'h1FF : 32'h100 + 32'(k));
      tx_ack = 2'b01;
    end
    nop();
    check("tx_empty_data", 32'(tx_data[23:0]), 32'h0);
    rd(8'h01, 32'h1, "gsr_ch0");

    // ch0 TX underflow, clear, clear racing a new underflow, ack+write on empty
    @(negedge clk);
    clr_in();
    tx_ack = 2'b01;
    nop();
    rd(8'h10, 32'h0000_000A, "tx_unf_sr");
    check("tx_unf_data", 32'(tx_data[23:0]), 32'h0);
    wr(8'h10, 32'h2);
    nop();
    rd(8'h10, 32'h0000_0008, "tx_unf_cleared");
    @(negedge clk);
    clr_in();
    wr_en   = 1'b1;
    wr_addr = 8'h10;
    wr_data = 32'h2;
    tx_ack  = 2'b01;
    nop();
    rd(8'h10, 32'h0000_000A, "tx_unf_set_wins");
    @(negedge clk);
    clr_in();
    wr_en   = 1'b1;
    wr_addr = 8'h12;
    wr_data = 32'h55;
    tx_ack  = 2'b01;
    #1 check("tx_empty_push_ack_err", 32'(wr_err), 32'h0);
    nop();
    check("tx_empty_push_lands", 32'(tx_data[23:0]), 32'h55);
    rd(8'h10, 32'h0001_000A, "tx_lvl1_sr");

    // ch0 RX extension of a negative and a positive sample
    wr(8'h11, 32'h0002_0083);
    @(negedge clk);
    clr_in();
    rx_vld = 2'b01;
    rx_data[23:0] = 24'h800001;
    @(negedge clk);
    clr_in();
    rx_vld = 2'b01;
    rx_data[23:0] = 24'h123456;
    nop();
    rd(8'h13, EXP_NEG, "din_neg");
    rd(8'h13, 32'h0012_3456, "din_pos");

    // ch1 full RX with same-cycle push and pop, then disable flushes
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      clr_in();
      rx_vld = 2'b10;
      rx_data[47:24] = 24'h200 + 24'(k);
    end
    nop();
    rd(8'h14, 32'h0000_1014, "rx_full_sr2");
    @(negedge clk);
    clr_in();
    rx_vld = 2'b10;
    rx_data[47:24] = 24'h2FF;
    rd_en   = 1'b1;
    rd_addr = 8'h17;
    exp_q.push_back(32'h200);
    tag_q.push_back("rx_full_push_pop");
    nop();
    rd(8'h14, 32'h0000_1014, "rx_full_no_ovf");
    wr(8'h15, 32'h0);
    nop();
    rd(8'h14, 32'h0, "rx_flushed");

    // reset mid-transfer discards everything
    @(negedge clk);
    clr_in();
    rst = 1'b1;
    nop();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_irq", 32'(irq), 32'h0);
    check("rst2_tx_data", 32'(tx_data[23:0]), 32'h0);
    rd(8'h10, 32'h0, "rst2_sr0");
    rd(8'h11, 32'h0, "rst2_ctrl0");
    rd(8'h14, 32'h0, "rst2_sr1");
    wr(8'h11, 32'h2);
    nop();
    check("rst2_tx_empty", 32'(tx_data[23:0]), 32'h0);

    // report
    repeat (20) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      $display("FAIL rd_missing: got %0d reads outstanding, expected 0", exp_q.size());
      n_vec += exp_q.size();
      n_err += exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
